execute_muldiv: RTL

- Multi-cycle multiply/divide unit in the EX stage. It consumes the R-type funct field that alu_control ignores: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Owns the architectural HI/LO registers and runs 32-iteration shift-add multiply and restoring divide.
- Raises a stall to the pipeline while an operation is in flight and a dependent instruction is in EX.

---
 rtl/execute_muldiv_pkg.sv | 32 +++
 rtl/execute_muldiv_decode.sv | 31 +++
 rtl/execute_muldiv.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/execute_muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit.
// Funct codes, ALUOp encoding, FSM states and the decoded-op bundle.
package execute_muldiv_pkg;

   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   localparam logic [1:0] MD_IDLE = 2'd0;
   localparam logic [1:0] MD_MUL  = 2'd1;
   localparam logic [1:0] MD_DIV  = 2'd2;
   localparam logic [1:0] MD_FIX  = 2'd3;

   typedef struct packed {
      logic mult;
      logic multu;
      logic div;
      logic divu;
      logic mfhi;
      logic mthi;
      logic mflo;
      logic mtlo;
   } muldiv_op_t;

endpackage

// File: rtl/execute_muldiv_decode.sv
// Funct decoder for the multiply/divide unit.
// Produces a one-hot op only for live, unflushed R-type instructions.
module muldiv_decode
   import execute_muldiv_pkg::*;
(
   input  logic       valid,
   input  logic       flush,
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output muldiv_op_t op,
   output logic       is_muldiv
);

   logic live;

   // Qualify the funct field, then match each code
   always_comb begin
      live     = valid & ~flush & (alu_op == ALUOP_RTYPE);
      op       = '0;
      op.mult  = live & (funct == FUNCT_MULT);
      op.multu = live & (funct == FUNCT_MULTU);
      op.div   = live & (funct == FUNCT_DIV);
      op.divu  = live & (funct == FUNCT_DIVU);
      op.mfhi  = live & (funct == FUNCT_MFHI);
      op.mthi  = live & (funct == FUNCT_MTHI);
      op.mflo  = live & (funct == FUNCT_MFLO);
      op.mtlo  = live & (funct == FUNCT_MTLO);
      is_muldiv = |op;
   end

endmodule

// File: rtl/execute_muldiv.sv
// EX-stage multi-cycle multiply/divide unit owning HI/LO.
// Shift-add multiply and restoring divide, one step per cycle.
module execute_muldiv
   import execute_muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             EX_valid,
   input  logic             EX_flush,
   input  logic [1:0]       EX_alu_op,
   input  logic [5:0]       EX_funct,
   input  logic [WIDTH-1:0] EX_rs_data,
   input  logic [WIDTH-1:0] EX_rt_data,
   output logic             EX_muldiv_stall,
   output logic             EX_muldiv_busy,
   output logic [WIDTH-1:0] EX_muldiv_result,
   output logic [WIDTH-1:0] EX_hi,
   output logic [WIDTH-1:0] EX_lo
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   muldiv_op_t op;
   logic       is_muldiv;

   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic               neg_lo;
   logic               neg_hi;
   logic               kind_div;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;

   logic               busy;
   logic               stall;
   logic               start_mul;
   logic               start_div;
   logic               is_signed;
   logic               rs_neg;
   logic               rt_neg;
   logic               rt_zero;
   logic [WIDTH-1:0]   rs_mag;
   logic [WIDTH-1:0]   rt_mag;
   logic               start_neg_lo;
   logic               start_neg_hi;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   muldiv_decode u_decode (
      .valid     (EX_valid),
      .flush     (EX_flush),
      .alu_op    (EX_alu_op),
      .funct     (EX_funct),
      .op        (op),
      .is_muldiv (is_muldiv)
   );

   // Handshake, operand magnitudes and start-time sign flags
   always_comb begin
      busy      = (state != MD_IDLE);
      stall     = busy & is_muldiv;
      start_mul = ~busy & (op.mult | op.multu);
      start_div = ~busy & (op.div | op.divu);
      is_signed = op.mult | op.div;
      rs_neg    = is_signed & EX_rs_data[WIDTH-1];
      rt_neg    = is_signed & EX_rt_data[WIDTH-1];
      rt_zero   = (EX_rt_data == '0);
      rs_mag    = rs_neg ? -EX_rs_data : EX_rs_data;
      rt_mag    = rt_neg ? -EX_rt_data : EX_rt_data;
      // Divide by zero keeps an all-ones quotient, so never negate it
      start_neg_lo = (rs_neg ^ rt_neg) & ~(start_div & rt_zero);
      start_neg_hi = start_div & rs_neg;
   end

   // One iteration step of each algorithm
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, opnd} : '0);
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
      if (!div_trial[WIDTH])
         div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         div_next = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
   end

   // Sign correction applied when leaving FIX
   always_comb begin
      prod_fix = neg_lo ? -acc : acc;
      quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_hi   = kind_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = kind_div ? quo_fix : prod_fix[WIDTH-1:0];
   end

   // Iteration FSM and work registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= MD_IDLE;
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         kind_div <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (start_mul) begin
                  state    <= MD_MUL;
                  cnt      <= '0;
                  acc      <= {{WIDTH{1'b0}}, rt_mag};
                  opnd     <= rs_mag;
                  neg_lo   <= start_neg_lo;
                  neg_hi   <= 1'b0;
                  kind_div <= 1'b0;
               end else if (start_div) begin
                  state    <= MD_DIV;
                  cnt      <= '0;
                  acc      <= {{WIDTH{1'b0}}, rs_mag};
                  opnd     <= rt_mag;
                  neg_lo   <= start_neg_lo;
                  neg_hi   <= start_neg_hi;
                  kind_div <= 1'b1;
               end
            end
            MD_MUL: begin
               acc <= mul_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST)
                  state <= MD_FIX;
            end
            MD_DIV: begin
               acc <= div_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST)
                  state <= MD_FIX;
            end
            MD_FIX: begin
               state <= MD_IDLE;
            end
            default: begin
               state <= MD_IDLE;
            end
         endcase
      end
   end

   // Architectural HI/LO: FIX result or an unstalled MT write
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else if (state == MD_FIX) begin
         hi <= fix_hi;
         lo <= fix_lo;
      end else if (!busy) begin
         if (op.mthi)
            hi <= EX_rs_data;
         if (op.mtlo)
            lo <= EX_rs_data;
      end
   end

   // MFHI/MFLO read-out, zero whenever stalled or not a move-from
   always_comb begin
      EX_muldiv_result = '0;
      if (!stall && op.mfhi)
         EX_muldiv_result = hi;
      else if (!stall && op.mflo)
         EX_muldiv_result = lo;
   end

   assign EX_muldiv_stall = stall;
   assign EX_muldiv_busy  = busy;
   assign EX_hi           = hi;
   assign EX_lo           = lo;

endmodule
